// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute-stage issue logic and muldiv_unit.
// The master drives operands and pipeline control; the slave returns status and result.
interface muldiv_unit_if #(
    parameter int XLEN = 64
);
    logic            start_in;
    logic [2:0]      funct3_in;
    logic            word_op_in;
    logic [XLEN-1:0] rs1_value_in;
    logic [XLEN-1:0] rs2_value_in;
    logic            stall_signal_in;
    logic            flush_signal_in;
    logic            busy_out;
    logic            done_out;
    logic [XLEN-1:0] result_out;

    modport master (
        output start_in, funct3_in, word_op_in,
        output rs1_value_in, rs2_value_in,
        output stall_signal_in, flush_signal_in,
        input  busy_out, done_out, result_out
    );

    modport slave (
        input  start_in, funct3_in, word_op_in,
        input  rs1_value_in, rs2_value_in,
        input  stall_signal_in, flush_signal_in,
        output busy_out, done_out, result_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the execute stage.
// Radix-2 shift-add multiply and restoring divide on operand magnitudes.
module muldiv_unit #(
    parameter int XLEN   = 64,
    parameter int ITER_D = 64,
    parameter int ITER_W = 32
) (
    input logic          clk_in,
    input logic          rst_in,
    muldiv_unit_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = $clog2(ITER_D + 1);
    localparam int W2 = 2 * XLEN;
    localparam int XH = XLEN - 32;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            is_div_q, is_div_d;
    logic            is_rem_q, is_rem_d;
    logic            hi_q, hi_d;
    logic            word_q, word_d;
    logic            neg_q, neg_d;
    logic [W2-1:0]   mcand_q, mcand_d;
    logic [W2-1:0]   prod_q, prod_d;
    logic [XLEN-1:0] mplier_q, mplier_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] divsr_q, divsr_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            f_div, f_rem, f_hi, f_word;
    logic            a_sgn, b_sgn, s_a, s_b, div0, ovf;
    logic [XLEN-1:0] op_a, op_b, mag_a, mag_b;
    logic [XLEN-1:0] dvd_w, min_neg, special;

    always_comb begin
        f_div  = bus.funct3_in[2];
        f_rem  = bus.funct3_in[2] & bus.funct3_in[1];
        f_hi   = ~bus.funct3_in[2] & (bus.funct3_in[1:0] != 2'b00);
        f_word = bus.word_op_in & ~f_hi;
        a_sgn  = !(bus.funct3_in inside {3'b011, 3'b101, 3'b111});
        b_sgn  = bus.funct3_in inside {3'b000, 3'b001, 3'b100, 3'b110};
        op_a   = f_word
               ? {{XH{a_sgn & bus.rs1_value_in[31]}}, bus.rs1_value_in[31:0]}
               : bus.rs1_value_in;
        op_b   = f_word
               ? {{XH{b_sgn & bus.rs2_value_in[31]}}, bus.rs2_value_in[31:0]}
               : bus.rs2_value_in;
        s_a    = a_sgn & op_a[XLEN-1];
        s_b    = b_sgn & op_b[XLEN-1];
        mag_a  = s_a ? -op_a : op_a;
        mag_b  = s_b ? -op_b : op_b;
        dvd_w  = f_word
               ? {{XH{bus.rs1_value_in[31]}}, bus.rs1_value_in[31:0]}
               : bus.rs1_value_in;
        min_neg = f_word
                ? {{(XH + 1){1'b1}}, 31'd0}
                : {1'b1, {(XLEN - 1){1'b0}}};
        div0 = f_div & (op_b == '0);
        ovf  = f_div & b_sgn & (op_a == min_neg) & (&op_b);
        // Corner cases bypass CALC and complete on the accept edge
        if (div0) special = f_rem ? dvd_w : '1;
        else      special = f_rem ? '0 : dvd_w;
    end

    logic [W2-1:0]   prod_nx, mag_res, sgn_res;
    logic [XLEN:0]   rem_sh;
    logic            ge;
    logic [XLEN-1:0] rem_nx, quo_nx, pick, res_fin;

    always_comb begin
        prod_nx = mplier_q[0] ? prod_q + mcand_q : prod_q;
        rem_sh  = {rem_q, quo_q[XLEN-1]};
        ge      = rem_sh >= {1'b0, divsr_q};
        rem_nx  = ge ? rem_sh[XLEN-1:0] - divsr_q : rem_sh[XLEN-1:0];
        quo_nx  = {quo_q[XLEN-2:0], ge};
        if (!is_div_q) mag_res = prod_nx;
        else           mag_res = {{XLEN{1'b0}}, is_rem_q ? rem_nx : quo_nx};
        sgn_res = neg_q ? -mag_res : mag_res;
        pick    = hi_q ? sgn_res[W2-1:XLEN] : sgn_res[XLEN-1:0];
        res_fin = word_q ? {{XH{pick[31]}}, pick[31:0]} : pick;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        is_rem_d = is_rem_q;
        hi_d     = hi_q;
        word_d   = word_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        divsr_d  = divsr_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start_in & ~bus.flush_signal_in) begin
                    is_div_d = f_div;
                    is_rem_d = f_rem;
                    hi_d     = f_hi;
                    word_d   = f_word;
                    neg_d    = f_rem ? s_a : s_a ^ s_b;
                    cnt_d    = f_word ? CW'(ITER_W - 1) : CW'(ITER_D - 1);
                    mcand_d  = {{XLEN{1'b0}}, mag_a};
                    prod_d   = '0;
                    mplier_d = mag_b;
                    // Word dividends start at the top so the same step walks bit 31 first
                    quo_d    = f_word ? {mag_a[31:0], {XH{1'b0}}} : mag_a;
                    rem_d    = '0;
                    divsr_d  = mag_b;
                    if (div0 | ovf) begin
                        state_d  = S_DONE;
                        result_d = special;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (bus.flush_signal_in) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d   = prod_nx;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    quo_d    = quo_nx;
                    rem_d    = rem_nx;
                    cnt_d    = cnt_q - CW'(1);
                    if (cnt_q == '0) begin
                        state_d  = S_DONE;
                        result_d = res_fin;
                    end
                end
            end
            S_DONE: begin
                if (bus.flush_signal_in | ~bus.stall_signal_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            is_rem_q <= 1'b0;
            hi_q     <= 1'b0;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            divsr_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            is_rem_q <= is_rem_d;
            hi_q     <= hi_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            divsr_q  <= divsr_d;
            result_q <= result_d;
        end
    end

    assign bus.busy_out   = (state_q == S_CALC)
                          | ((state_q == S_DONE) & bus.stall_signal_in);
    assign bus.done_out   = (state_q == S_DONE);
    assign bus.result_out = result_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit in the execute stage, directly downstream of the general purpose register file.
- Consumes the registered rs1/rs2 operand values plus decoded funct3/word-op flags. Produces a 64-bit result for the writeback path.
- Multi-cycle. While busy, the unit asks the hazard logic to stall the front of the pipe.

Parameters:
- XLEN, 64, operand/result width.
- ITER_D, 64, iterations for doubleword ops.
- ITER_W, 32, iterations for word (*W) ops.

Ports:
- clk_in  input  1  clock; all state updates on posedge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  request to begin an operation; sampled only in IDLE.
- funct3_in  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- word_op_in  input  1  selects MULW/DIVW/DIVUW/REMW/REMUW; valid only with funct3 000/100/101/110/111.
- rs1_value_in  input  64  operand A, from the register file rs1_value_out.
- rs2_value_in  input  64  operand B, from the register file rs2_value_out.
- stall_signal_in  input  1  downstream cannot accept a result.
- flush_signal_in  input  1  kill the in-flight operation.
- busy_out  output  1  high in CALC, and in DONE while stalled.
- done_out  output  1  result valid.
- result_out  output  64  final result.

Behaviour:
- Reset: state=IDLE, busy_out=0, done_out=0, result_out=0, all internal registers 0. Reset mid-operation abandons the operation; no done_out follows.

State machine (IDLE, CALC, DONE):
- IDLE -> CALC when start_in & ~flush_signal_in. Operands, funct3 and word_op are latched on that edge; later input changes are ignored.
- IDLE -> DONE directly (1-cycle latency) for divide special cases:
  - divisor==0: DIV/DIVU quotient = all ones; REM/REMU = dividend.
  - signed overflow (most negative / -1): DIV = dividend; REM = 0.
  - For word ops, "dividend", "all ones" and "most negative" are the 32-bit values, sign-extended to 64.
- CALC: one radix-2 step per cycle for ITER cycles (ITER_W if word op, else ITER_D). An internal counter runs ITER-1 down to 0. CALC -> DONE on the edge where the counter is 0.
- DONE: done_out=1 and result_out valid.
  - DONE -> IDLE on the first edge with stall_signal_in=0.
  - While stall_signal_in=1, remain in DONE with result_out and done_out held.
  - start_in is ignored in DONE; there is no back-to-back accept in the same edge.
- Normal latency: accept at edge k; done_out first high in the cycle after edge k+ITER. That is 65 cycles for doubleword, 33 for word.
- flush_signal_in=1 in CALC or DONE: -> IDLE next edge, done_out=0, result_out unchanged. Flush has priority over stall and start. Flush in IDLE also blocks acceptance.
- busy_out = (state==CALC) | (state==DONE & stall_signal_in).
- result_out changes only on entry to DONE, and holds its value in IDLE.

Arithmetic:
- Multiply: shift-add on magnitudes with sign correction.
  - MUL returns product[63:0]; MULH/MULHSU/MULHU return product[127:64].
  - Signedness: MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned.
- Divide: restoring division on magnitudes.
  - Quotient sign = sign(A) xor sign(B).
  - Remainder sign = sign(A).
- Word ops:
  - Operands are taken from [31:0]; signed ops sign-extend, unsigned ops zero-extend.
  - The 32-bit result is sign-extended to 64, including DIVUW/REMUW.
- Invalid word_op with funct3 001/010/011: treat as word_op=0.

Test Plan:
- MUL: A=7, B=-3 (0xFFFF_FFFF_FFFF_FFFD) -> done_out high 65 cycles after accept, result=0xFFFF_FFFF_FFFF_FFEB; busy_out high for cycles 1..64.
- MULHU: A=B=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. MULH with A=0x8000_0000_0000_0000, B=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV: A=-20, B=6 -> quotient -3 (0xFFFF_FFFF_FFFF_FFFD). REM with the same operands -> -2.
- Word ops: DIVW A=0x0000_0001_8000_0000, B=-1 -> 1-cycle special case, result 0xFFFF_FFFF_8000_0000. REMUW A=0xFFFF_FFFF, B=0x10 -> 0xF in 33 cycles.
- Divide by zero: DIVU A=5, B=0 -> done next cycle, result 0xFFFF_FFFF_FFFF_FFFF. REM A=5, B=0 -> 5.
- Flush/stall/reset:
  - Flush at CALC cycle 10 -> IDLE, no done_out, new start accepted next edge.
  - stall_signal_in high 3 cycles in DONE -> done_out and result held 4 cycles total.
  - rst_in mid-CALC -> all outputs 0 next edge.
